// File: rtl/demux_stream_1xn_if.sv
// Stream bundle for the 1-to-N demultiplexer: one producer side, N consumer channels.
// Also carries the err_o and drop_o status flags.
interface demux_stream_1xn_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
);
  logic [DATA_W-1:0]      x_i;
  logic [SEL_W-1:0]       sel_i;
  logic                   valid_i;
  logic                   ready_o;
  logic [N_CH*DATA_W-1:0] y_o;
  logic [N_CH-1:0]        valid_o;
  logic [N_CH-1:0]        ready_i;
  logic                   err_o;
  logic                   drop_o;

  modport master (
    output x_i, sel_i, valid_i, ready_i,
    input  ready_o, y_o, valid_o, err_o, drop_o
  );

  modport slave (
    input  x_i, sel_i, valid_i, ready_i,
    output ready_o, y_o, valid_o, err_o, drop_o
  );
endinterface

// File: rtl/demux_stream_1xn.sv
// 1-to-N streaming demultiplexer with a one-word holding slot per channel.
// Words with an out-of-range select are accepted and dropped, raising a sticky error.
module demux_stream_1xn #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  demux_stream_1xn_if.slave bus
);
  localparam int SEL_W_REQ = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1;

  if (SEL_W != SEL_W_REQ) begin : g_bad_sel_w
    $error("demux_stream_1xn: SEL_W must equal max(1, clog2(N_CH))");
  end

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t       state_q [N_CH];
  slot_state_t       state_d [N_CH];
  logic [DATA_W-1:0] data_q  [N_CH];
  logic [N_CH-1:0]   load;
  logic              sel_hit;
  logic              ready;
  logic              drop_now;
  logic              err_q;
  logic              drop_q;

  // An unmatched select means out of range: always ready, so the word is swallowed.
  always_comb begin
    sel_hit = 1'b0;
    ready   = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      if (bus.sel_i == SEL_W'(k)) begin
        sel_hit = 1'b1;
        ready   = (state_q[k] == EMPTY) || bus.ready_i[k];
      end
    end
  end

  always_comb begin
    load = '0;
    for (int k = 0; k < N_CH; k++) begin
      state_d[k] = state_q[k];
      load[k]    = bus.valid_i && ready && (bus.sel_i == SEL_W'(k));
      if (load[k]) begin
        state_d[k] = FULL;
      end else if ((state_q[k] == FULL) && bus.ready_i[k]) begin
        state_d[k] = EMPTY;
      end
    end
  end

  assign drop_now = bus.valid_i && !sel_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
      end
      err_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= state_d[k];
        if (load[k]) begin
          data_q[k] <= bus.x_i;
        end
      end
      drop_q <= drop_now;
      if (drop_now) begin
        err_q <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_out
    assign bus.y_o[k*DATA_W +: DATA_W] = data_q[k];
    assign bus.valid_o[k]              = (state_q[k] == FULL);
  end

  assign bus.ready_o = ready;
  assign bus.err_o   = err_q;
  assign bus.drop_o  = drop_q;
endmodule

// File: tb/tb_demux_stream_1xn.sv
// Directed bench for demux_stream_1xn: vector table on a 4-channel instance,
// plus a hand-written out-of-range/drop sequence on a 3-channel instance.
module tb_demux_stream_1xn;
  logic clk = 1'b0;
  logic rst4;
  logic rst3;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  demux_stream_1xn_if #(.N_CH(4), .DATA_W(8), .SEL_W(2)) bus4 ();
  demux_stream_1xn_if #(.N_CH(3), .DATA_W(8), .SEL_W(2)) bus3 ();

  demux_stream_1xn #(.N_CH(4), .DATA_W(8), .SEL_W(2)) dut4 (
    .clk_i(clk), .rst_i(rst4), .bus(bus4)
  );

  demux_stream_1xn #(.N_CH(3), .DATA_W(8), .SEL_W(2)) dut3 (
    .clk_i(clk), .rst_i(rst3), .bus(bus3)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [1:0]  sel;
    logic [7:0]  x;
    logic [3:0]  rdy;
    logic        chk_ready;
    logic        exp_ready;
    logic [3:0]  exp_valid;
    logic [31:0] exp_y;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic valid, input logic [1:0] sel,
                              input logic [7:0] x, input logic [3:0] rdy,
                              input logic chk_ready, input logic exp_ready,
                              input logic [3:0] exp_valid, input logic [31:0] exp_y);
    vec_t v;
    v.rst = rst; v.valid = valid; v.sel = sel; v.x = x; v.rdy = rdy;
    v.chk_ready = chk_ready; v.exp_ready = exp_ready;
    v.exp_valid = exp_valid; v.exp_y = exp_y;
    vecs.push_back(v);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    rst4          = v.rst;
    bus4.valid_i  = v.valid;
    bus4.sel_i    = v.sel;
    bus4.x_i      = v.x;
    bus4.ready_i  = v.rdy;
  endtask

  initial begin
    rst4 = 1'b1;
    rst3 = 1'b1;
    bus4.valid_i = 1'b0; bus4.sel_i = '0; bus4.x_i = '0; bus4.ready_i = '0;
    bus3.valid_i = 1'b0; bus3.sel_i = '0; bus3.x_i = '0; bus3.ready_i = '0;

    // rst valid sel x rdy chk exp_rdy exp_valid exp_y
    add(1, 0, 0, 8'h00, 4'hF, 0, 0, 4'b0000, 32'h00000000);
    add(0, 1, 0, 8'hA0, 4'hF, 1, 1, 4'b0001, 32'h000000A0);
    add(0, 1, 1, 8'hA1, 4'hF, 1, 1, 4'b0010, 32'h0000A1A0);
    add(0, 1, 2, 8'hA2, 4'hF, 1, 1, 4'b0100, 32'h00A2A1A0);
    add(0, 1, 3, 8'hA3, 4'hF, 1, 1, 4'b1000, 32'hA3A2A1A0);
    add(0, 0, 0, 8'h00, 4'hF, 1, 1, 4'b0000, 32'hA3A2A1A0);
    add(0, 1, 2, 8'h11, 4'hB, 1, 1, 4'b0100, 32'hA311A1A0);
    add(0, 1, 2, 8'h22, 4'hB, 1, 0, 4'b0100, 32'hA311A1A0);
    add(0, 1, 2, 8'h22, 4'hF, 1, 1, 4'b0100, 32'hA322A1A0);
    add(0, 1, 1, 8'h33, 4'hB, 1, 1, 4'b0110, 32'hA32233A0);
    add(0, 0, 0, 8'h00, 4'hB, 1, 1, 4'b0100, 32'hA32233A0);
    for (int i = 1; i <= 8; i++)
      add(0, 1, 0, 8'(i), 4'hB, 1, 1, 4'b0101, {24'hA32233, 8'(i)});
    add(0, 0, 0, 8'h00, 4'hF, 1, 1, 4'b0000, 32'hA3223308);
    add(0, 1, 0, 8'hC0, 4'h6, 1, 1, 4'b0001, 32'hA32233C0);
    add(0, 1, 3, 8'hC3, 4'h6, 1, 1, 4'b1001, 32'hC32233C0);
    add(0, 1, 0, 8'hEE, 4'h6, 1, 0, 4'b1001, 32'hC32233C0);
    add(1, 1, 1, 8'hD1, 4'h0, 0, 0, 4'b0000, 32'h00000000);
    add(0, 0, 1, 8'h00, 4'hF, 1, 1, 4'b0000, 32'h00000000);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      #3;
      if (vecs[i].chk_ready)
        check_output($sformatf("v%0d ready_o", i), 32'(bus4.ready_o), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      check_output($sformatf("v%0d valid_o", i), 32'(bus4.valid_o), 32'(vecs[i].exp_valid));
      check_output($sformatf("v%0d y_o", i), bus4.y_o, vecs[i].exp_y);
      check_output($sformatf("v%0d err_o", i), 32'(bus4.err_o), 32'h0);
      check_output($sformatf("v%0d drop_o", i), 32'(bus4.drop_o), 32'h0);
    end

    // Three-channel instance: sel=3 is out of range and must be dropped.
    rst3 = 1'b0;
    bus3.ready_i = 3'b111;
    bus3.valid_i = 1'b1; bus3.sel_i = 2'd3; bus3.x_i = 8'h55;
    #3;
    check_output("n3 oor ready_o", 32'(bus3.ready_o), 32'h1);
    @(posedge clk); #1;
    check_output("n3 drop pulse", 32'(bus3.drop_o), 32'h1);
    check_output("n3 err set", 32'(bus3.err_o), 32'h1);
    check_output("n3 no valid", 32'(bus3.valid_o), 32'h0);
    bus3.valid_i = 1'b1; bus3.sel_i = 2'd2; bus3.x_i = 8'h66;
    @(posedge clk); #1;
    check_output("n3 drop cleared", 32'(bus3.drop_o), 32'h0);
    check_output("n3 err sticky", 32'(bus3.err_o), 32'h1);
    check_output("n3 ch2 valid", 32'(bus3.valid_o), 32'h4);
    check_output("n3 ch2 data", bus3.y_o, 32'h00660000);
    bus3.valid_i = 1'b0;
    rst3 = 1'b1;
    @(posedge clk); #1;
    check_output("n3 reset err", 32'(bus3.err_o), 32'h0);
    check_output("n3 reset drop", 32'(bus3.drop_o), 32'h0);
    check_output("n3 reset valid", 32'(bus3.valid_o), 32'h0);
    check_output("n3 reset y", bus3.y_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
